// File: rtl/fsm_seq_ctrl.sv
// Sequencer that walks the idle/start/stop/clear FSM through one
// high-low-high-low cycle on `a` and confirms each step on `k2`.
module fsm_seq_ctrl #(
    parameter int CNT_W  = 8,
    parameter int TO_CYC = 16,
    parameter int RUN_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [CNT_W-1:0] len_hi,
    input  logic [CNT_W-1:0] len_lo,
    output logic             a,
    input  logic             k2,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [RUN_W-1:0] runs
);

    localparam int TO_W = (TO_CYC > 2) ? $clog2(TO_CYC) : 2;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
    localparam logic [TO_W-1:0] W_ONE = TO_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        HI1,
        LO1,
        HI2,
        LO2
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic [CNT_W-1:0] lo_q, lo_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [TO_W-1:0]  wcnt, wcnt_d;
    logic             a_d, busy_d, done_d, err_d;
    logic [RUN_W-1:0] runs_d;
    logic             w_last;

    assign w_last = (wcnt == TO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            hi_q  <= '0;
            lo_q  <= '0;
            cnt   <= '0;
            wcnt  <= '0;
            a     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            runs  <= '0;
        end else begin
            state <= state_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt   <= cnt_d;
            wcnt  <= wcnt_d;
            a     <= a_d;
            busy  <= busy_d;
            done  <= done_d;
            err   <= err_d;
            runs  <= runs_d;
        end
    end

    // Lengths are latched already clamped to >=1, so hi_q-1 never wraps.
    always_comb begin
        state_d = state;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt;
        wcnt_d  = wcnt;
        unique case (state)
            IDLE: begin
                if (go) begin
                    hi_d    = (len_hi == '0) ? C_ONE : len_hi;
                    lo_d    = (len_lo == '0) ? C_ONE : len_lo;
                    cnt_d   = '0;
                    state_d = HI1;
                end
            end
            HI1: begin
                if (cnt == hi_q - C_ONE) begin
                    cnt_d   = '0;
                    state_d = LO1;
                end else begin
                    cnt_d = cnt + C_ONE;
                end
            end
            LO1: begin
                if (cnt == lo_q - C_ONE) begin
                    cnt_d   = '0;
                    wcnt_d  = '0;
                    state_d = HI2;
                end else begin
                    cnt_d = cnt + C_ONE;
                end
            end
            HI2: begin
                if (k2) begin
                    wcnt_d  = '0;
                    state_d = LO2;
                end else if (w_last) begin
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt + W_ONE;
                end
            end
            LO2: begin
                if (!k2 || w_last) begin
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt + W_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with it.
    always_comb begin
        a_d    = (state_d == HI1) || (state_d == HI2);
        busy_d = (state_d != IDLE);
        done_d = (state == LO2) && !k2;
        err_d  = ((state == HI2) && !k2 && w_last) ||
                 ((state == LO2) && k2 && w_last);
        runs_d = runs + RUN_W'(done_d);
    end

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Bench for fsm_seq_ctrl: behavioural model plus per-cycle compare,
// a small reference FSM for k2, and directed literal checks.
module tb_fsm_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       go;
    logic [7:0] len_hi, len_lo;
    logic       a, k2, busy, done, err;
    logic [15:0] runs;

    int checks = 0;
    int errors = 0;

    fsm_seq_ctrl #(.CNT_W(8), .TO_CYC(16), .RUN_W(16)) dut (
        .clk(clk), .reset(reset), .go(go),
        .len_hi(len_hi), .len_lo(len_lo),
        .a(a), .k2(k2), .busy(busy),
        .done(done), .err(err), .runs(runs)
    );

    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference idle/start/stop/clear FSM; k2 high while in clear.
    int   fst;
    logic fk2, sk2, fsm_clr;
    int   k2mode;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            fst <= 0; fk2 <= 1'b0; sk2 <= 1'b0;
        end else if (fsm_clr) begin
            fst <= 0; fk2 <= 1'b0; sk2 <= 1'b0;
        end else begin
            sk2 <= sk2 | fk2;
            case (fst)
                0: if (a) fst <= 1;
                1: if (!a) fst <= 2;
                2: if (a) begin fst <= 3; fk2 <= 1'b1; end
                default: if (!a) begin fst <= 0; fk2 <= 1'b0; end
            endcase
        end
    end

    always_comb begin
        k2 = fk2;
        if (k2mode == 1) k2 = 1'b0;
        if (k2mode == 2) k2 = fk2 | sk2;
    end

    // Model: phase 0 idle, 1 hi1, 2 lo1, 3 hi2, 4 lo2; n = cycles spent.
    int ph, n, lh, ll, m_runs;
    bit m_done, m_err;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ph = 0; n = 0; m_runs = 0; m_done = 0; m_err = 0;
        end else begin
            m_done = 0; m_err = 0;
            case (ph)
                0: if (go) begin
                    lh = (len_hi == 0) ? 1 : int'(len_hi);
                    ll = (len_lo == 0) ? 1 : int'(len_lo);
                    ph = 1; n = 0;
                end
                1: begin n++; if (n == lh) begin ph = 2; n = 0; end end
                2: begin n++; if (n == ll) begin ph = 3; n = 0; end end
                3: if (k2) begin ph = 4; n = 0; end
                   else begin
                       n++;
                       if (n == 16) begin m_err = 1; ph = 0; end
                   end
                default: if (!k2) begin
                       m_done = 1; ph = 0;
                       m_runs = (m_runs + 1) % 65536;
                   end else begin
                       n++;
                       if (n == 16) begin m_err = 1; ph = 0; end
                   end
            endcase
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            check("m_a", 64'(a), 64'(ph == 1 || ph == 3));
            check("m_busy", 64'(busy), 64'(ph != 0));
            check("m_done", 64'(done), 64'(m_done));
            check("m_err", 64'(err), 64'(m_err));
            check("m_runs", 64'(runs), 64'(m_runs));
        end
    end

    logic [39:0] va, vd, ve, vb;
    task automatic capture(input int cyc, input bit hold);
        va = '0; vd = '0; ve = '0; vb = '0;
        for (int i = 1; i <= cyc; i++) begin
            @(negedge clk);
            if (!hold && i == 1) go = 1'b0;
            va[i] = a; vd[i] = done; ve[i] = err; vb[i] = busy;
        end
    endtask

    task automatic setup(input logic [7:0] h, input logic [7:0] l,
                         input int mode);
        @(negedge clk);
        fsm_clr = 1'b1; len_hi = h; len_lo = l; k2mode = mode;
        @(negedge clk);
        fsm_clr = 1'b0; go = 1'b1;
    endtask

    initial begin
        reset = 1'b0; go = 1'b0; len_hi = 8'd0; len_lo = 8'd0;
        k2mode = 0; fsm_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_a", 64'(a), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done_err", 64'({done, err}), 64'd0);
        check("rst_runs", 64'(runs), 64'd0);
        reset = 1'b1;

        setup(8'd3, 8'd2, 0);
        capture(12, 0);
        check("t1_a", 64'(va), 64'h0CE);
        check("t1_done", 64'(vd), 64'h400);
        check("t1_err", 64'(ve), 64'h0);
        check("t1_runs", 64'(runs), 64'd1);

        setup(8'd1, 8'd1, 1);
        capture(20, 0);
        check("t2_a", 64'(va), 64'h7FFFA);
        check("t2_err", 64'(ve), 64'h80000);
        check("t2_busy", 64'(vb), 64'h7FFFE);
        check("t2_done", 64'(vd), 64'h0);
        check("t2_runs", 64'(runs), 64'd1);

        setup(8'd1, 8'd1, 2);
        capture(22, 0);
        check("t3_a", 64'(va), 64'h1A);
        check("t3_err", 64'(ve), 64'h200000);
        check("t3_runs", 64'(runs), 64'd1);

        setup(8'd0, 8'd0, 0);
        capture(8, 0);
        check("t4_a", 64'(va), 64'h1A);
        check("t4_done", 64'(vd), 64'h80);
        check("t4_runs", 64'(runs), 64'd2);

        setup(8'd2, 8'd1, 0);
        va = '0; vd = '0; vb = '0;
        for (int i = 1; i <= 26; i++) begin
            @(negedge clk);
            va[i] = a; vd[i] = done; vb[i] = busy;
            if (i == 1) len_hi = 8'd5;
            if (i == 5) len_hi = 8'd2;
            if (i == 24) go = 1'b0;
        end
        check("t5_a", 64'(va), 64'h363636);
        check("t5_done", 64'(vd), 64'h1010100);
        check("t5_busy9", 64'(vb[9]), 64'd1);
        check("t5_busy17", 64'(vb[17]), 64'd1);
        check("t5_idle25", 64'(vb[25]), 64'd0);
        check("t5_runs", 64'(runs), 64'd5);

        setup(8'd3, 8'd2, 0);
        capture(4, 0);
        #2 reset = 1'b0;
        #1;
        check("t6_a", 64'(a), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_done_err", 64'({done, err}), 64'd0);
        check("t6_runs", 64'(runs), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        setup(8'd3, 8'd2, 0);
        capture(12, 0);
        check("t6b_a", 64'(va), 64'h0CE);
        check("t6b_done", 64'(vd), 64'h400);
        check("t6b_err", 64'(ve), 64'h0);
        check("t6b_runs", 64'(runs), 64'd1);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
